// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer with a valid/ready output slot and one-entry skid buffer.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_next_pc,
    input  logic        i_redirect,
    output logic [31:0] o_pc_plus4,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    input  logic        i_if_ready,
    output logic [31:0] o_if_pc,
`ifdef MISALIGN_TRAP_EN
    output logic        o_fetch_misalign,
`endif
    output logic [31:0] o_if_instr
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_SLOT
`ifdef MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_pc, r_instr, r_skid_pc, r_skid_instr, r_redir_pc;
    logic        r_valid, r_drop;
    logic [31:0] w_tgt;
    logic        w_consume, w_ack_ok;

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_tgt            = i_next_pc;
    assign o_fetch_misalign = r_misalign;
`else
    assign w_tgt = i_next_pc & ~32'h3;
`endif

    assign o_pc_plus4  = r_addr + 32'd4;
    assign o_imem_req  = (r_state == REQ);
    assign o_imem_addr = r_addr;
    assign o_if_valid  = r_valid;
    assign o_if_pc     = r_pc;
    assign o_if_instr  = r_instr;
    assign w_consume   = r_valid & i_if_ready;
    assign w_ack_ok    = i_imem_ack & !i_redirect & !r_drop;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = REQ;
            REQ:       w_next = (w_ack_ok & r_valid & !i_if_ready) ? WAIT_SLOT : REQ;
            WAIT_SLOT: w_next = (i_redirect | i_if_ready) ? REQ : WAIT_SLOT;
`ifdef MISALIGN_TRAP_EN
            FAULT:     w_next = i_redirect ? REQ : FAULT;
`endif
            default:   w_next = IDLE;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (i_redirect && (|i_next_pc[1:0]) && r_state != IDLE) w_next = FAULT;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr       <= RESET_PC;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
            r_drop       <= 1'b0;
            r_redir_pc   <= RESET_PC;
            r_skid_pc    <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            // Drained or flushed slot falls back to NOP unless a branch below refills it.
            if (w_consume | i_redirect) begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
            case (r_state)
                IDLE: r_addr <= RESET_PC;
                REQ: begin
                    if (i_redirect) begin
                        if (i_imem_ack) begin
                            r_addr <= w_tgt;
                            r_drop <= 1'b0;
                        end else begin
                            r_redir_pc <= w_tgt;
                            r_drop     <= 1'b1;
                        end
                    end else if (i_imem_ack & r_drop) begin
                        r_addr <= r_redir_pc;
                        r_drop <= 1'b0;
                    end else if (i_imem_ack & (!r_valid | i_if_ready)) begin
                        r_valid <= 1'b1;
                        r_pc    <= r_addr;
                        r_instr <= i_imem_rdata;
                        r_addr  <= w_tgt;
                    end else if (i_imem_ack) begin
                        r_skid_pc    <= r_addr;
                        r_skid_instr <= i_imem_rdata;
                    end
                end
                WAIT_SLOT: begin
                    if (i_redirect) r_addr <= w_tgt;
                    else if (i_if_ready) begin
                        r_valid <= 1'b1;
                        r_pc    <= r_skid_pc;
                        r_instr <= r_skid_instr;
                        r_addr  <= r_skid_pc + 32'd4;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                FAULT: if (i_redirect) r_addr <= w_tgt;
`endif
                default: r_addr <= RESET_PC;
            endcase
`ifdef MISALIGN_TRAP_EN
            r_misalign <= (w_next == FAULT);
            if (w_next == FAULT) r_drop <= 1'b0;
`endif
        end
    end
endmodule
